dest_pop_counter: RTL
=====================

Name: dest_pop_counter

Overview:
- Downstream consumer of the interconnect's D0/D1 egress FIFOs.
- Pops both FIFOs whenever they hold data and popping is enabled, and counts delivered words per destination and in total.
- Checks every delivered word for misrouting.
- Exposes the counts to the probador through a request/index readout handshake that is honoured only while the system FSM reports idle.

Parameters:
BW, 6, data word width; bit BW-2 is the destination bit (0 = D0, 1 = D1)
CW, 5, counter width; counters saturate at 2^CW-1

Ports:
clk  input  1  system clock
reset_L  input  1  asynchronous active-low reset
pop_en  input  1  pop enable from system FSM (active state)
idle  input  1  system FSM idle indication; readout is permitted only when high
D0_empty  input  1  D0 FIFO empty
D1_empty  input  1  D1 FIFO empty
D0_data_out  input  BW  D0 FIFO read data, valid the cycle after D0_rd
D1_data_out  input  BW  D1 FIFO read data, valid the cycle after D1_rd
D0_rd  output  1  D0 FIFO pop
D1_rd  output  1  D1 FIFO pop
req  input  1  counter readout request, sampled on rising clk
idx  input  2  counter select: 0 = D0, 1 = D1, 2 = total, 3 = reserved
cnt_valid  output  1  readout data valid, one-cycle pulse
cnt_data  output  CW  readout counter value
misroute  output  1  sticky: a word with the wrong destination bit was delivered

Behaviour:
- Reset (reset_L low, asynchronous): all counters 0, cnt_valid 0, cnt_data 0, misroute 0, pipeline valids 0, FSM to RUN.
- The reset clears state immediately mid-operation; any in-flight pop is discarded and not counted.
- Pop, combinational:
  - D0_rd = reset_L & pop_en & ~D0_empty.
  - D1_rd = reset_L & pop_en & ~D1_empty.
  - Both may be high in the same cycle; no arbitration is applied.
- Capture stage: registered v0 <= D0_rd and v1 <= D1_rd. In the cycle where v0 or v1 is high, the matching D*_data_out is consumed.
- Counting, on the edge ending a cycle with v0/v1 high:
  - cnt_d0 += v0; cnt_d1 += v1.
  - cnt_tot += v0 + v1, so +2 when both are high.
  - Each counter saturates at 2^CW-1 and never wraps.
  - cnt_tot saturates independently, including the +2 case from 2^CW-2 (result is 2^CW-1).
- Misroute check:
  - Set if v0 and D0_data_out[BW-2] == 1, or v1 and D1_data_out[BW-2] == 0.
  - Sticky until reset. The offending word is still counted.
- FSM, two states:
  - RUN: counting active. req sampled high with idle low is ignored; no cnt_valid and no queuing.
  - RUN -> READ when req & idle.
  - READ: cnt_valid = 1 for exactly one cycle with cnt_data = the counter selected by the idx registered with the request (idx 3 returns 0). Then return to RUN.
  - Counting continues in READ. The reported value is the counter value at the edge that sampled req; an increment on that same edge is not included.
  - Latency: cnt_valid is asserted in the cycle following the req sample.
  - A req held high yields one pulse every 2 cycles.
- cnt_valid is 0 in RUN; cnt_data holds its last value while cnt_valid is 0.
- pop_en deasserting mid-burst: no new pops are issued; words already in the capture stage are still counted.

Decomposition:
- Shared package (interconnect defines): BW, CW, DEST_BIT = BW-2, idx encodings (IDX_D0 = 0, IDX_D1 = 1, IDX_TOT = 2), FSM state encodings (ST_RUN, ST_READ).
- One sub-module: sat_counter, a CW-bit saturating counter with 2-bit increment, used three times.
- Pop, capture, misroute and FSM logic stay in the top level.

Test Plan:
- Reset, then 3 words dest0 into D0 and 2 words dest1 into D1, pop_en = 1, then idle = 1, req with idx = 0/1/2 -> cnt_data 3, 2, 5, each with a one-cycle cnt_valid, 1 cycle after req.
- Both FIFOs non-empty on the same cycles for 4 cycles -> D0_rd and D1_rd high together; cnt_tot = 8, cnt_d0 = cnt_d1 = 4.
- Saturation, CW = 5:
  - 33 words to D0 -> cnt_d0 = 31.
  - 40 words split 20/20 -> cnt_tot = 31, no wrap to 0.
- D1 delivers a word with bit BW-2 = 0 -> misroute rises the cycle after capture and stays 1; word still counted; cleared only by reset_L.
- req with idle = 0 -> no cnt_valid. req with idx = 3 and idle = 1 -> cnt_valid = 1, cnt_data = 0.
- Pop in flight (v0 = 1) when reset_L drops asynchronously between edges -> counters read 0 after reset, D0_rd low during reset, misroute = 0.

Source files
------------

// File: rtl/dest_pop_counter_pkg.sv
// Shared interconnect defines for the destination pop counter.
// Word/counter widths, readout selects and FSM states.
package dest_pop_counter_pkg;

  localparam int BW       = 6;
  localparam int CW       = 5;
  localparam int DEST_BIT = BW - 2;

  localparam logic [1:0] IDX_D0  = 2'd0;
  localparam logic [1:0] IDX_D1  = 2'd1;
  localparam logic [1:0] IDX_TOT = 2'd2;

  typedef enum logic {
    ST_RUN,
    ST_READ
  } state_e;

endpackage

// File: rtl/dest_pop_counter_if.sv
// Egress FIFO pop and counter readout bundle.
// master = FIFO/probador side, slave = counter block.
interface dest_pop_counter_if;
  import dest_pop_counter_pkg::*;

  logic          D0_empty;
  logic          D1_empty;
  logic [BW-1:0] D0_data_out;
  logic [BW-1:0] D1_data_out;
  logic          D0_rd;
  logic          D1_rd;
  logic          req;
  logic [1:0]    idx;
  logic          cnt_valid;
  logic [CW-1:0] cnt_data;

  modport master (
    output D0_empty, D1_empty,
    output D0_data_out, D1_data_out,
    output req, idx,
    input  D0_rd, D1_rd,
    input  cnt_valid, cnt_data
  );

  modport slave (
    input  D0_empty, D1_empty,
    input  D0_data_out, D1_data_out,
    input  req, idx,
    output D0_rd, D1_rd,
    output cnt_valid, cnt_data
  );

endinterface

// File: rtl/dest_pop_counter_sat_counter.sv
// Saturating up-counter with a 0..2 increment per cycle.
// One spare sum bit flags overflow so the count pins at all-ones.
module sat_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   inc_i,
  output logic [W-1:0] cnt_o
);

  localparam logic [W-1:0] MAX = '1;

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic [W:0]   sum;

  always_comb begin
    sum   = {1'b0, cnt_q} + {{(W-1){1'b0}}, inc_i};
    cnt_d = sum[W] ? MAX : sum[W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/dest_pop_counter.sv
// Pops the D0/D1 egress FIFOs, counts delivered words and flags
// misrouted ones; counts are read out only while the system is idle.
module dest_pop_counter
  import dest_pop_counter_pkg::*;
(
  input  logic                clk,
  input  logic                reset_L,
  input  logic                pop_en,
  input  logic                idle,
  dest_pop_counter_if.slave   bus,
  output logic                misroute
);

  logic          v0_q;
  logic          v1_q;
  logic          mis_q;
  logic          mis_d;
  state_e        state_q;
  logic          cnt_valid_q;
  logic [CW-1:0] cnt_data_q;
  logic [CW-1:0] cnt_d0;
  logic [CW-1:0] cnt_d1;
  logic [CW-1:0] cnt_tot;
  logic [CW-1:0] sel_cnt;

  assign bus.D0_rd = reset_L & pop_en & ~bus.D0_empty;
  assign bus.D1_rd = reset_L & pop_en & ~bus.D1_empty;

  // A word is misrouted when its destination bit disagrees with its FIFO.
  always_comb begin
    mis_d = mis_q;
    if (v0_q && bus.D0_data_out[DEST_BIT])
      mis_d = 1'b1;
    if (v1_q && !bus.D1_data_out[DEST_BIT])
      mis_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      v0_q  <= 1'b0;
      v1_q  <= 1'b0;
      mis_q <= 1'b0;
    end else begin
      v0_q  <= bus.D0_rd;
      v1_q  <= bus.D1_rd;
      mis_q <= mis_d;
    end
  end

  sat_counter #(.W(CW)) u_cnt_d0 (
    .clk   (clk),
    .rst_n (reset_L),
    .inc_i ({1'b0, v0_q}),
    .cnt_o (cnt_d0)
  );

  sat_counter #(.W(CW)) u_cnt_d1 (
    .clk   (clk),
    .rst_n (reset_L),
    .inc_i ({1'b0, v1_q}),
    .cnt_o (cnt_d1)
  );

  sat_counter #(.W(CW)) u_cnt_tot (
    .clk   (clk),
    .rst_n (reset_L),
    .inc_i ({1'b0, v0_q} + {1'b0, v1_q}),
    .cnt_o (cnt_tot)
  );

  always_comb begin
    sel_cnt = '0;
    unique case (1'b1)
      (bus.idx == IDX_D0):  sel_cnt = cnt_d0;
      (bus.idx == IDX_D1):  sel_cnt = cnt_d1;
      (bus.idx == IDX_TOT): sel_cnt = cnt_tot;
      default:              sel_cnt = '0;
    endcase
  end

  // Value is captured on the sampling edge, so a same-edge
  // increment is not part of the reported count.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= ST_RUN;
      cnt_valid_q <= 1'b0;
      cnt_data_q  <= '0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (bus.req && idle) begin
            state_q     <= ST_READ;
            cnt_valid_q <= 1'b1;
            cnt_data_q  <= sel_cnt;
          end
        end
        ST_READ: begin
          state_q     <= ST_RUN;
          cnt_valid_q <= 1'b0;
        end
        default: begin
          state_q     <= ST_RUN;
          cnt_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cnt_valid = cnt_valid_q;
  assign bus.cnt_data  = cnt_data_q;
  assign misroute      = mis_q;

endmodule
